// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: port bundle for the ID-stage register file with scoreboard.
// master = core side (drives writeback/issue/flush/read indices),
// slave  = register file (returns read data and busy status).
interface reg_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2
);
  // writeback port
  logic                     reg_write;
  logic [ADDR_W-1:0]        reg_dest;
  logic [DATA_W-1:0]        data;
  // issue / flush for the pending-write scoreboard
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_dest;
  logic                     flush;
  // read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
  logic [NUM_RD*ADDR_W-1:0] src;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output reg_write, reg_dest, data, issue_valid, issue_dest, flush, src,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  reg_write, reg_dest, data, issue_valid, issue_dest, flush, src,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: NUM_REGS x DATA_W register file, NUM_RD combinational read
// ports, one writeback port, and a per-register pending-write scoreboard
// used by ID-stage hazard logic.
// Indices NUM_REGS..2^ADDR_W-1 belong to the PC: they read as 0, never busy,
// and writes/issues to them are ignored.
// Optional feature: define RF_BYPASS_EN for same-cycle write-to-read bypass.

// Per-port read lane: register select, out-of-range masking, optional bypass.
module reg_file_sb_rd #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             pend,
  input  logic [ADDR_W-1:0]               src,
`ifdef RF_BYPASS_EN
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_dest,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            iss_en,
  input  logic [ADDR_W-1:0]               iss_dest,
`endif
  output logic [DATA_W-1:0]               rd_data,
  output logic                            rd_busy
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic in_rng;
  assign in_rng = {1'b0, src} < NREGS;

  // select storage/pending bit; PC-reserved indices return 0 and not busy
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (in_rng) begin
      rd_data = regs[src];
      rd_busy = pend[src];
`ifdef RF_BYPASS_EN
      // writeback landing this edge is forwarded; it also resolves the
      // hazard unless a fresh issue to the same register happens together
      if (wr_en && (wr_dest == src)) begin
        rd_data = wr_data;
        if (!(iss_en && (iss_dest == src)))
          rd_busy = 1'b0;
      end
`endif
    end
  end
endmodule

module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave rf
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pend;
  logic [NUM_REGS-1:0]             pend_nxt;

  logic [NUM_RD-1:0][ADDR_W-1:0]   src_a;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_a;
  logic [NUM_RD-1:0]               rd_busy_a;

  // qualified (in-range) write and issue strobes
  logic wr_en;
  logic iss_en;
  assign wr_en  = rf.reg_write   && ({1'b0, rf.reg_dest}   < NREGS);
  assign iss_en = rf.issue_valid && ({1'b0, rf.issue_dest} < NREGS);

  // storage: reset loads register i with i; flush does not block writeback
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(i);
    end else if (wr_en) begin
      regs[rf.reg_dest] <= rf.data;
    end
  end

  // scoreboard next state: flush > issue set > writeback clear > hold
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_en && (rf.issue_dest == ADDR_W'(i)))
        pend_nxt[i] = 1'b1;
      else if (wr_en && (rf.reg_dest == ADDR_W'(i)))
        pend_nxt[i] = 1'b0;
    end
    if (rf.flush)
      pend_nxt = '0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (!rst) pend <= '0;
    else      pend <= pend_nxt;
  end

  assign src_a       = rf.src;
  assign rf.rd_data  = rd_data_a;
  assign rf.rd_busy  = rd_busy_a;
  assign rf.busy_vec = pend;

  // one read lane per port
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_sb_rd #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W)
    ) u_rd (
      .regs    (regs),
      .pend    (pend),
      .src     (src_a[k]),
`ifdef RF_BYPASS_EN
      .wr_en   (wr_en),
      .wr_dest (rf.reg_dest),
      .wr_data (rf.data),
      .iss_en  (iss_en),
      .iss_dest(rf.issue_dest),
`endif
      .rd_data (rd_data_a[k]),
      .rd_busy (rd_busy_a[k])
    );
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench with an expected-value scoreboard queue.
module tb_reg_file_sb;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 15;
  localparam int ADDR_W   = 4;
  localparam int NUM_RD   = 2;

  localparam int P0 = 0, P1 = 1, BV = 2, RB0 = 3, RB1 = 4;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) rf();

  reg_file_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf)
  );

  typedef struct {
    string       tag;
    int          what;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] observe(int what);
    case (what)
      P0:      return rf.rd_data[31:0];
      P1:      return rf.rd_data[63:32];
      BV:      return 32'(rf.busy_vec);
      RB0:     return 32'(rf.rd_busy[0]);
      default: return 32'(rf.rd_busy[1]);
    endcase
  endfunction

  task automatic push(input string tag, input int what, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.what = what; e.exp = exp;
    sb.push_back(e);
  endtask

  // let combinational outputs settle, then compare everything queued
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.what);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // advance past a rising edge; inputs are changed 2ns after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int a, input int b);
    rf.src = {4'(b), 4'(a)};
  endtask

  task automatic idle();
    rf.reg_write = 1'b0; rf.reg_dest = '0; rf.data = '0;
    rf.issue_valid = 1'b0; rf.issue_dest = '0; rf.flush = 1'b0;
  endtask

  initial begin
    idle();
    set_src(0, 0);
    rst = 1'b0;
    tick(); tick();
    push("reset_busy_vec", BV, 32'h0);
    push("reset_rd_busy0", RB0, 32'h0);
    drain();
    rst = 1'b1;

    // reset contents sweep, both ports on the same index
    for (int s = 0; s < 16; s++) begin
      tick();
      set_src(s, s);
      push("sweep_p0", P0, (s < NUM_REGS) ? 32'(s) : 32'h0);
      push("sweep_p1", P1, (s < NUM_REGS) ? 32'(s) : 32'h0);
      push("sweep_busy0", RB0, 32'h0);
      drain();
    end

    // write r3 with a same-cycle read on both ports
    tick();
    set_src(3, 3);
    rf.reg_write = 1'b1; rf.reg_dest = 4'd3; rf.data = 32'hDEADBEEF;
    push("wr_same_p0", P0, BYP ? 32'hDEADBEEF : 32'd3);
    push("wr_same_p1", P1, BYP ? 32'hDEADBEEF : 32'd3);
    drain();
    tick();
    idle();
    push("wr_next_p0", P0, 32'hDEADBEEF);
    push("wr_next_p1", P1, 32'hDEADBEEF);
    drain();

    // issue r5: busy only from the following cycle
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd5;
    set_src(5, 0);
    push("iss_cycle_busy0", RB0, 32'h0);
    drain();
    tick(); idle(); tick();
    push("iss5_busy_vec", BV, 32'h20);
    push("iss5_busy0", RB0, 32'h1);
    push("iss5_busy1_r0", RB1, 32'h0);
    drain();
    rf.reg_write = 1'b1; rf.reg_dest = 4'd5; rf.data = 32'h55;
    push("wb5_same_p0", P0, BYP ? 32'h55 : 32'd5);
    push("wb5_same_busy0", RB0, BYP ? 32'h0 : 32'h1);
    drain();
    tick(); idle();
    push("wb5_busy_vec", BV, 32'h0);
    push("wb5_p0", P0, 32'h55);
    drain();

    // issue and writeback r7 together: issue wins the scoreboard
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd7;
    rf.reg_write = 1'b1; rf.reg_dest = 4'd7; rf.data = 32'h77;
    set_src(7, 0);
    push("iw7_same_p0", P0, BYP ? 32'h77 : 32'd7);
    push("iw7_same_busy0", RB0, 32'h0);
    drain();
    tick(); idle();
    push("iw7_p0", P0, 32'h77);
    push("iw7_busy_vec", BV, 32'h80);
    push("iw7_busy0", RB0, 32'h1);
    drain();

    // issue r1, r2, r4, then flush alongside writeback r2
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd1; tick();
    rf.issue_dest = 4'd2; tick();
    rf.issue_dest = 4'd4; tick();
    idle();
    set_src(2, 4);
    push("pre_flush_busy_vec", BV, 32'h96);
    push("pre_flush_busy0", RB0, 32'h1);
    push("pre_flush_busy1", RB1, 32'h1);
    drain();
    rf.flush = 1'b1;
    rf.reg_write = 1'b1; rf.reg_dest = 4'd2; rf.data = 32'h22;
    tick(); idle();
    push("flush_busy_vec", BV, 32'h0);
    push("flush_wb_p0", P0, 32'h22);
    push("flush_p1_r4", P1, 32'd4);
    drain();

    // reset with a concurrent write and issue to r0
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd6; tick();
    idle();
    push("pre_rst_busy_vec", BV, 32'h40);
    drain();
    rst = 1'b0;
    rf.reg_write = 1'b1; rf.reg_dest = 4'd0; rf.data = 32'hFFFF;
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd0;
    tick();
    rst = 1'b1; idle();
    set_src(0, 3);
    push("rst_mid_p0_r0", P0, 32'h0);
    push("rst_mid_p1_r3", P1, 32'd3);
    push("rst_mid_busy_vec", BV, 32'h0);
    drain();

    // write and issue to the PC-reserved index have no effect
    rf.reg_write = 1'b1; rf.reg_dest = 4'd15; rf.data = 32'hABCD;
    rf.issue_valid = 1'b1; rf.issue_dest = 4'd15;
    tick(); idle();
    push("idx15_busy_vec", BV, 32'h0);
    drain();
    for (int s = 0; s < 16; s++) begin
      tick();
      set_src(s, 15 - s);
      push("idx15_p0", P0, (s < NUM_REGS) ? 32'(s) : 32'h0);
      push("idx15_p1", P1, ((15 - s) < NUM_REGS) ? 32'(15 - s) : 32'h0);
      push("idx15_busy1", RB1, 32'h0);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
